// File: rtl/sbox_roundtrip_bist.sv
// Built-in self-test for a combined AES S-box (forward + inverse behind one
// encrypt select). Each byte x is sent forward, and the result is sent back
// through the inverse. The block checks that x comes back, that the forward
// map has no repeated outputs, that three anchor values are right, and that
// the forward outputs sum to the golden value.
//
// Ports
//   clk, reset_n       : clock and asynchronous active-low reset
//   start, abort       : start a run (only in IDLE/DONE) and cancel a run
//   sbox_encrypt       : S-box select to the S-box (1 = forward, 0 = inverse)
//   sbox_byte_in       : byte sent to the S-box
//   sbox_byte_out      : combinational S-box response
//   busy, done, pass   : run status and verdict (pass is valid with done)
//   fail_count         : number of failing input bytes (0..256)
//   first_fail_addr    : first failing input byte (0x00 if none)
//   anchor_fail        : an anchor value was wrong
//   fwd_sum            : sum of all forward outputs, mod 2^16
module sbox_roundtrip_bist (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        sbox_encrypt,
  output logic [7:0]  sbox_byte_in,
  input  logic [7:0]  sbox_byte_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  fail_count,
  output logic [7:0]  first_fail_addr,
  output logic        anchor_fail,
  output logic [15:0] fwd_sum
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned SEEN_W = 256;

  localparam logic [SUM_W-1:0]  GOLDEN_SUM = SUM_W'(16'h7F80);
  localparam logic [BYTE_W-1:0] LAST_X     = BYTE_W'(8'hFF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_INV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [BYTE_W-1:0]   x, x_d;
  logic [BYTE_W-1:0]   s, s_d;
  logic [SEEN_W-1:0]   seen, seen_d;
  logic                fail_flag, fail_flag_d;
  logic                sbox_encrypt_d;
  logic [BYTE_W-1:0]   sbox_byte_in_d;
  logic                busy_d, done_d, pass_d;
  logic [CNT_W-1:0]    fail_count_d;
  logic [BYTE_W-1:0]   first_fail_addr_d;
  logic                anchor_fail_d;
  logic [SUM_W-1:0]    fwd_sum_d;
  logic                clear_c;
  logic                mismatch_c;
  logic                anchor_bad_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      x               <= '0;
      s               <= '0;
      seen            <= '0;
      fail_flag       <= 1'b0;
      sbox_encrypt    <= 1'b1;
      sbox_byte_in    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      anchor_fail     <= 1'b0;
      fwd_sum         <= '0;
    end else begin
      state           <= state_d;
      x               <= x_d;
      s               <= s_d;
      seen            <= seen_d;
      fail_flag       <= fail_flag_d;
      sbox_encrypt    <= sbox_encrypt_d;
      sbox_byte_in    <= sbox_byte_in_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      fail_count      <= fail_count_d;
      first_fail_addr <= first_fail_addr_d;
      anchor_fail     <= anchor_fail_d;
      fwd_sum         <= fwd_sum_d;
    end
  end

  // Next-state and next-output logic. S-box drive values are registered
  // one cycle ahead so they already hold x (FWD) or s (INV) in that state.
  always_comb begin
    state_d           = state;
    x_d               = x;
    s_d               = s;
    seen_d            = seen;
    fail_flag_d       = fail_flag;
    sbox_encrypt_d    = sbox_encrypt;
    sbox_byte_in_d    = sbox_byte_in;
    busy_d            = busy;
    done_d            = done;
    pass_d            = pass;
    fail_count_d      = fail_count;
    first_fail_addr_d = first_fail_addr;
    anchor_fail_d     = anchor_fail;
    fwd_sum_d         = fwd_sum;
    clear_c           = 1'b0;
    mismatch_c        = 1'b0;
    anchor_bad_c      = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_FWD;
          clear_c        = 1'b1;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          sbox_encrypt_d = 1'b1;
          sbox_byte_in_d = '0;
        end else if (abort && (state == ST_DONE)) begin
          state_d = ST_IDLE;
          clear_c = 1'b1;
          done_d  = 1'b0;
        end
      end

      ST_FWD: begin
        if (abort) begin
          state_d        = ST_IDLE;
          clear_c        = 1'b1;
          busy_d         = 1'b0;
          sbox_encrypt_d = 1'b1;
          sbox_byte_in_d = '0;
        end else begin
          s_d       = sbox_byte_out;
          fwd_sum_d = fwd_sum + SUM_W'(sbox_byte_out);
          // A repeated forward output means the map is not a permutation
          if (seen[sbox_byte_out]) fail_flag_d = 1'b1;
          seen_d[sbox_byte_out] = 1'b1;
          unique case (x)
            8'h00:   anchor_bad_c = (sbox_byte_out != 8'h63);
            8'h53:   anchor_bad_c = (sbox_byte_out != 8'hED);
            8'hFF:   anchor_bad_c = (sbox_byte_out != 8'h16);
            default: anchor_bad_c = 1'b0;
          endcase
          if (anchor_bad_c) begin
            fail_flag_d   = 1'b1;
            anchor_fail_d = 1'b1;
          end
          state_d        = ST_INV;
          sbox_encrypt_d = 1'b0;
          sbox_byte_in_d = sbox_byte_out;
        end
      end

      ST_INV: begin
        if (abort) begin
          state_d        = ST_IDLE;
          clear_c        = 1'b1;
          busy_d         = 1'b0;
          sbox_encrypt_d = 1'b1;
          sbox_byte_in_d = '0;
        end else begin
          mismatch_c = (sbox_byte_out != x);
          // Any failure for this x counts once
          if (mismatch_c || fail_flag) begin
            fail_count_d = fail_count + CNT_W'(1);
            if (fail_count == '0) first_fail_addr_d = x;
          end
          fail_flag_d    = 1'b0;
          sbox_encrypt_d = 1'b1;
          if (x == LAST_X) begin
            state_d        = ST_DONE;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            sbox_byte_in_d = '0;
            pass_d         = (fail_count_d == '0) && (fwd_sum == GOLDEN_SUM)
                             && !anchor_fail;
          end else begin
            state_d        = ST_FWD;
            x_d            = x + BYTE_W'(1);
            sbox_byte_in_d = x + BYTE_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared clear for start and abort
    if (clear_c) begin
      x_d               = '0;
      s_d               = '0;
      seen_d            = '0;
      fail_flag_d       = 1'b0;
      pass_d            = 1'b0;
      fail_count_d      = '0;
      first_fail_addr_d = '0;
      anchor_fail_d     = 1'b0;
      fwd_sum_d         = '0;
    end
  end

endmodule

// File: tb/tb_sbox_roundtrip_bist.sv
// Self-checking bench for sbox_roundtrip_bist. A behavioural AES S-box with
// optional planted faults answers the BIST; expected verdicts are queued
// when each run starts and compared when done rises.
module tb_sbox_roundtrip_bist;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        sbox_encrypt;
  logic [7:0]  sbox_byte_in;
  logic [7:0]  sbox_byte_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  fail_count;
  logic [7:0]  first_fail_addr;
  logic        anchor_fail;
  logic [15:0] fwd_sum;

  int unsigned mode;
  int          n_checks;
  int          n_errors;

  typedef struct packed {
    logic [8:0]  fc;
    logic [7:0]  ffa;
    logic        anc;
    logic [15:0] sum;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];

  sbox_roundtrip_bist dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .sbox_encrypt   (sbox_encrypt),
    .sbox_byte_in   (sbox_byte_in),
    .sbox_byte_out  (sbox_byte_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_addr(first_fail_addr),
    .anchor_fail    (anchor_fail),
    .fwd_sum        (fwd_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hFE;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] v);
    logic [7:0] b;
    b = ginv(v);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] v);
    return ginv(rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05);
  endfunction

  // Fault modes: 0 golden, 1 inverse(0x7C)^0x01, 2 fwd(0x10)=0x63, 3 fwd(0x53)=0xEC
  function automatic logic [7:0] ut_fwd(input int unsigned m, input logic [7:0] v);
    if (m == 2 && v == 8'h10) return 8'h63;
    if (m == 3 && v == 8'h53) return 8'hEC;
    return sbox_fwd(v);
  endfunction

  function automatic logic [7:0] ut_inv(input int unsigned m, input logic [7:0] v);
    if (m == 1 && v == 8'h7C) return sbox_inv(v) ^ 8'h01;
    return sbox_inv(v);
  endfunction

  always_comb begin
    sbox_byte_out = 8'h00;
    if (sbox_encrypt) sbox_byte_out = ut_fwd(mode, sbox_byte_in);
    else              sbox_byte_out = ut_inv(mode, sbox_byte_in);
  end

  // Reference verdict for a full sweep against the given S-box
  function automatic exp_t model_run(input int unsigned m);
    exp_t e;
    logic [255:0] sn;
    logic [7:0] f, r, xb;
    logic bad;
    e = '0;
    sn = '0;
    for (int i = 0; i < 256; i++) begin
      xb = 8'(i);
      f = ut_fwd(m, xb);
      e.sum = e.sum + 16'(f);
      bad = sn[f];
      sn[f] = 1'b1;
      if ((xb == 8'h00 && f != 8'h63) || (xb == 8'h53 && f != 8'hED) ||
          (xb == 8'hFF && f != 8'h16)) begin
        bad = 1'b1;
        e.anc = 1'b1;
      end
      r = ut_inv(m, f);
      if (bad || r != xb) begin
        if (e.fc == 9'd0) e.ffa = xb;
        e.fc = e.fc + 9'd1;
      end
    end
    e.pass = (e.fc == 9'd0) && (e.sum == 16'h7F80) && !e.anc;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_fc"}, 32'(fail_count), 32'd0);
    check({tag, "_ffa"}, 32'(first_fail_addr), 32'd0);
    check({tag, "_anc"}, 32'(anchor_fail), 32'd0);
    check({tag, "_sum"}, 32'(fwd_sum), 32'd0);
    check({tag, "_enc"}, 32'(sbox_encrypt), 32'd1);
    check({tag, "_bin"}, 32'(sbox_byte_in), 32'd0);
  endtask

  // Full run: queue the expectation, pulse start, count busy cycles until done
  task automatic run(input int unsigned m, input bit mid_start);
    exp_t e;
    int cyc;
    bit seen_done;
    mode = m;
    exp_q.push_back(model_run(m));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_low", 32'(done), 32'd0);
    cyc = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) cyc++;
      if (sbox_encrypt == 1'b0 && busy && sbox_byte_out != ut_inv(m, sbox_byte_in)) begin
        check("sbox_env", 32'(sbox_byte_out), 32'(ut_inv(m, sbox_byte_in)));
      end
      start = mid_start && (cyc == 200);
      @(negedge clk);
    end
    start = 1'b0;
    check("run_done_seen", 32'(seen_done), 32'd1);
    check("busy_cycles", 32'(cyc), 32'd512);
    check("done_busy_low", 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("fail_count", 32'(fail_count), 32'(e.fc));
      check("first_fail_addr", 32'(first_fail_addr), 32'(e.ffa));
      check("anchor_fail", 32'(anchor_fail), 32'(e.anc));
      check("fwd_sum", 32'(fwd_sum), 32'(e.sum));
      check("pass", 32'(pass), 32'(e.pass));
    end
    check("done_enc", 32'(sbox_encrypt), 32'd1);
    check("done_bin", 32'(sbox_byte_in), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mode     = 0;
    start    = 1'b0;
    abort    = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Golden S-box
    run(0, 1'b0);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_sum", 32'(fwd_sum), 32'h7F80);
    check("golden_fc", 32'(fail_count), 32'd0);

    // Corrupted inverse (restart straight from DONE)
    run(1, 1'b0);
    check("inv_fault_fc", 32'(fail_count), 32'd1);
    check("inv_fault_ffa", 32'(first_fail_addr), 32'h01);
    check("inv_fault_sum", 32'(fwd_sum), 32'h7F80);
    check("inv_fault_pass", 32'(pass), 32'd0);

    // Duplicate forward output at 0x10
    run(2, 1'b0);
    check("dup_ffa", 32'(first_fail_addr), 32'h10);
    check("dup_pass", 32'(pass), 32'd0);
    check("dup_sum_changed", 32'(fwd_sum != 16'h7F80), 32'd1);

    // Wrong anchor S(0x53)
    run(3, 1'b0);
    check("anchor_flag", 32'(anchor_fail), 32'd1);
    check("anchor_pass", 32'(pass), 32'd0);
    check("anchor_fc_nonzero", 32'(fail_count != 9'd0), 32'd1);

    // Abort from DONE clears results
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort_done");

    // Abort mid-run at cycle 100, with start held too
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check_idle_outputs("abort_run");
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    run(0, 1'b0);
    check("after_abort_pass", 32'(pass), 32'd1);

    // Asynchronous reset mid-run at cycle 300
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Full run after reset with a start pulse ignored mid-run
    run(0, 1'b1);
    check("mid_start_pass", 32'(pass), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sbox_roundtrip_bist.md
# sbox_roundtrip_bist

Sequential built-in self-test that drives any combined AES S-box (encrypt select, `byte_in`, `byte_out`) from the opposite side of its interface. It sweeps all 256 inputs through the forward S-box, feeds each result back through the inverse S-box, and checks that the original byte is recovered. It also checks that the forward map is a permutation and that three known anchor values are correct. It sits beside any S-box variant in the library and gives a pass/fail verdict.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a test run; sampled only in IDLE or DONE.
- `abort` input 1: cancel a run in progress.
- `sbox_encrypt` output 1: to the S-box `encrypt` input; 1 = forward, 0 = inverse.
- `sbox_byte_in` output 8: to the S-box `byte_in`.
- `sbox_byte_out` input 8: from the S-box `byte_out`; combinational response to the outputs above.
- `busy` output 1: high while in FWD or INV.
- `done` output 1: high in DONE until the next `start`, `abort` or reset.
- `pass` output 1: valid when `done`=1.
- `fail_count` output 9: number of failing input bytes (0..256).
- `first_fail_addr` output 8: first failing input byte; 0x00 if none.
- `anchor_fail` output 1: at least one anchor mismatch.
- `fwd_sum` output 16: sum of all forward outputs, mod 2^16.

## Operation
- States: IDLE, FWD, INV, DONE. An 8-bit counter `x` and an 8-bit register `s` hold the current input and forward result.
- IDLE/DONE + `start`=1:
  - Clear `x`, `fail_count`, `first_fail_addr`, `anchor_fail`, `fwd_sum`, the 256-bit `seen` vector and the per-byte fail flag.
  - Go to FWD.
- FWD: drive `sbox_encrypt`=1 and `sbox_byte_in`=`x`. At the clock edge:
  - `s` <= `sbox_byte_out`.
  - `fwd_sum` += `sbox_byte_out`.
  - If `seen[sbox_byte_out]` is already set, set the fail flag (duplicate output). Then set `seen[sbox_byte_out]`.
  - Anchor check: `x`=0x00 must give 0x63, 0x53 must give 0xED, 0xFF must give 0x16. A mismatch sets the fail flag and `anchor_fail`.
  - Go to INV.
- INV: drive `sbox_encrypt`=0 and `sbox_byte_in`=`s`. At the clock edge:
  - Mismatch if `sbox_byte_out` != `x`.
  - If the mismatch or the fail flag is set: `fail_count` += 1 (at most once per `x`). Latch `first_fail_addr`=`x` if this is the first failure.
  - Clear the fail flag.
  - If `x`=0xFF, go to DONE. Otherwise `x` += 1 and go to FWD.
- `pass` = (`fail_count`==0) && (`fwd_sum`==0x7F80) && !`anchor_fail`, qualified by `done`.
- `abort`=1 in FWD/INV: return to IDLE and clear all result registers. `done` is not asserted. `abort` in IDLE/DONE has no effect except that DONE moves to IDLE with results cleared.
- `start` while busy: ignored. `start` and `abort` together in FWD/INV: `abort` wins.
- In IDLE/DONE, `sbox_encrypt`=1 and `sbox_byte_in`=0x00.
- Reset (any state, including mid-run):
  - State IDLE.
  - All outputs 0 except `sbox_encrypt`=1.
  - `seen`, `s`, `x` and the fail flag cleared.

## Timing
- The S-box path is combinational. `sbox_byte_out` is sampled on the same edge that ends each FWD/INV cycle; there is no wait state.
- Edge E0 samples `start` in IDLE. FWD(x=0) occupies the cycle after E0. Each byte takes 2 cycles.
- INV(0xFF) ends at edge E512. `busy` falls and `done` rises immediately after E512.
- `busy` is high for exactly 512 cycles.
- `fail_count`, `first_fail_addr` and `fwd_sum` update at FWD/INV edges and are stable once `done`=1.
- Restart from DONE: the `start` edge clears results, and `done` falls in the same cycle that `busy` rises.

## Test plan
- Golden combined S-box attached, pulse `start` -> `busy` for 512 cycles; `done`=1, `pass`=1, `fail_count`=0, `fwd_sum`=0x7F80, `anchor_fail`=0, `first_fail_addr`=0x00.
- Inverse path corrupted (output XOR 0x01 when input is 0x7C) -> `fail_count`=1, `first_fail_addr`=0x01, `pass`=0, `fwd_sum`=0x7F80.
- Forward output for input 0x10 forced to 0x63 (duplicate of S(0x00)) -> duplicate flagged; `fail_count`>=1, `first_fail_addr`=0x00 or 0x10 per the first failure, `fwd_sum`≠0x7F80, `pass`=0.
- Forward S(0x53) forced to 0xEC -> `anchor_fail`=1, `pass`=0, `fail_count`>=1.
- `abort` at cycle 100 of a run, then `start` -> first run gives no `done`. All results read 0 in IDLE. The second run completes with `pass`=1 after 512 cycles.
- `reset_n` low at cycle 300 -> outputs at reset values immediately (asynchronous). `start` after release -> full 512-cycle run, `pass`=1. `start` pulsed mid-run -> ignored, run length unchanged.
